// File: rtl/tcp_rx_pipe_ctrl.sv
// tcp_rx_pipe_ctrl
//
// Control FSM for tcp_rx_datap. It takes one parsed TCP header at a time.
// It runs the flow CAM lookup and then follows one of three paths:
//   - hit      : read the flow state, compute, write it back, then notify
//                the scheduler and the payload destination
//   - SYN miss : pop a flowid, initialise the flow, notify the application
//                and enqueue a SYN-ACK
//   - other    : count the header as dropped
// Only control strobes and valid/ready signals are driven here. All data
// fields live in the datapath.
//
// Handshake rule for every valid/ready pair on this block: a transfer
// happens in a cycle where valid and ready are both high at the rising
// clock edge. A valid this block drives never depends combinationally on
// its own ready. Once raised, a valid holds until its transfer completes.
//
// Ports
//   clk, rst                          clock, asynchronous active-low reset
//   src_tcp_rx_hdr_val/_syn, tcp_rx_src_hdr_rdy     header input
//   read_flow_cam_val/_rdy, read_flow_cam_resp_val/_hit   CAM lookup
//   flowid_manager_req/_empty         flowid pop (flowid returned same cycle)
//   flow_state_rd_req_val/_rdy, flow_state_rd_resp_val   flow state read
//   flow_state_wr_req_val/_rdy        flow state write-back
//   new_flow_val/_rdy, app_new_flow_notif_val/_rdy,
//   slow_path_send_pkt_enqueue_val/_rdy              new-flow outputs
//   rx_sched_update_val/_rdy, tcp_rx_dst_hdr_val, dst_tcp_rx_hdr_rdy
//                                     fast-path outputs
//   ctrl_datap_save_input, ctrl_datap_save_flow_state, ctrl_datap_save_calcs,
//   store_flowid_cam, store_flowid_manager           datapath strobes
//   drop_cnt                          saturating dropped-header count
//   fsm_state                         current FSM state (debug)

module tcp_rx_pipe_ctrl #(
    parameter int DROP_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  src_tcp_rx_hdr_val,
    input  logic                  src_tcp_rx_syn,
    output logic                  tcp_rx_src_hdr_rdy,

    output logic                  read_flow_cam_val,
    input  logic                  read_flow_cam_rdy,
    input  logic                  read_flow_cam_resp_val,
    input  logic                  read_flow_cam_hit,

    output logic                  flowid_manager_req,
    input  logic                  flowid_manager_empty,

    output logic                  flow_state_rd_req_val,
    input  logic                  flow_state_rd_req_rdy,
    input  logic                  flow_state_rd_resp_val,

    output logic                  flow_state_wr_req_val,
    input  logic                  flow_state_wr_req_rdy,

    output logic                  new_flow_val,
    input  logic                  new_flow_rdy,
    output logic                  app_new_flow_notif_val,
    input  logic                  app_new_flow_notif_rdy,
    output logic                  slow_path_send_pkt_enqueue_val,
    input  logic                  slow_path_send_pkt_enqueue_rdy,

    output logic                  rx_sched_update_val,
    input  logic                  rx_sched_update_rdy,
    output logic                  tcp_rx_dst_hdr_val,
    input  logic                  dst_tcp_rx_hdr_rdy,

    output logic                  ctrl_datap_save_input,
    output logic                  ctrl_datap_save_flow_state,
    output logic                  ctrl_datap_save_calcs,
    output logic                  store_flowid_cam,
    output logic                  store_flowid_manager,

    output logic [DROP_CNT_W-1:0] drop_cnt,
    output logic [3:0]            fsm_state
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        LOOKUP  = 4'd1,
        RD_REQ  = 4'd2,
        RD_RESP = 4'd3,
        CALC    = 4'd4,
        WR      = 4'd5,
        FP_OUT  = 4'd6,
        NF_OUT  = 4'd7,
        DROP    = 4'd8
    } state_t;

    state_t state;
    state_t state_next;

    logic syn_q;
    logic done_sched;
    logic done_dst;
    logic done_new_flow;
    logic done_app;
    logic done_slow;

    // An output counts as finished if it finished earlier or transfers now.
    // This lets the FSM leave in the same cycle as the last transfer.
    logic fin_sched;
    logic fin_dst;
    logic fin_new_flow;
    logic fin_app;
    logic fin_slow;

    assign fsm_state = state;

    always_comb begin
        state_next                     = state;
        tcp_rx_src_hdr_rdy             = 1'b0;
        read_flow_cam_val              = 1'b0;
        flowid_manager_req             = 1'b0;
        flow_state_rd_req_val          = 1'b0;
        flow_state_wr_req_val          = 1'b0;
        new_flow_val                   = 1'b0;
        app_new_flow_notif_val         = 1'b0;
        slow_path_send_pkt_enqueue_val = 1'b0;
        rx_sched_update_val            = 1'b0;
        tcp_rx_dst_hdr_val             = 1'b0;
        ctrl_datap_save_input          = 1'b0;
        ctrl_datap_save_flow_state     = 1'b0;
        ctrl_datap_save_calcs          = 1'b0;
        store_flowid_cam               = 1'b0;
        store_flowid_manager           = 1'b0;
        fin_sched                      = 1'b0;
        fin_dst                        = 1'b0;
        fin_new_flow                   = 1'b0;
        fin_app                        = 1'b0;
        fin_slow                       = 1'b0;

        case (state)
            IDLE: begin
                // The IDLE outputs pass input signals straight through.
                // They are gated by reset so every output stays low while
                // reset is held.
                if (rst) begin
                    // The header and the CAM request share one handshake.
                    // A header is consumed only when the CAM accepts it.
                    tcp_rx_src_hdr_rdy = read_flow_cam_rdy;
                    read_flow_cam_val  = src_tcp_rx_hdr_val;
                    if (src_tcp_rx_hdr_val && read_flow_cam_rdy) begin
                        ctrl_datap_save_input = 1'b1;
                        state_next            = LOOKUP;
                    end
                end
            end
            LOOKUP: begin
                if (read_flow_cam_resp_val) begin
                    if (read_flow_cam_hit) begin
                        store_flowid_cam = 1'b1;
                        state_next       = RD_REQ;
                    end else if (syn_q && !flowid_manager_empty) begin
                        flowid_manager_req   = 1'b1;
                        store_flowid_manager = 1'b1;
                        state_next           = NF_OUT;
                    end else begin
                        state_next = DROP;
                    end
                end
            end
            RD_REQ: begin
                flow_state_rd_req_val = 1'b1;
                if (flow_state_rd_req_rdy) begin
                    state_next = RD_RESP;
                end
            end
            RD_RESP: begin
                if (flow_state_rd_resp_val) begin
                    ctrl_datap_save_flow_state = 1'b1;
                    state_next                 = CALC;
                end
            end
            CALC: begin
                // The datapath registers its computed next state on this
                // strobe. WR then presents stable registered data.
                ctrl_datap_save_calcs = 1'b1;
                state_next            = WR;
            end
            WR: begin
                flow_state_wr_req_val = 1'b1;
                if (flow_state_wr_req_rdy) begin
                    state_next = FP_OUT;
                end
            end
            FP_OUT: begin
                rx_sched_update_val = !done_sched;
                tcp_rx_dst_hdr_val  = !done_dst;
                fin_sched = done_sched | rx_sched_update_rdy;
                fin_dst   = done_dst | dst_tcp_rx_hdr_rdy;
                if (fin_sched && fin_dst) begin
                    state_next = IDLE;
                end
            end
            NF_OUT: begin
                new_flow_val                   = !done_new_flow;
                app_new_flow_notif_val         = !done_app;
                slow_path_send_pkt_enqueue_val = !done_slow;
                fin_new_flow = done_new_flow | new_flow_rdy;
                fin_app      = done_app | app_new_flow_notif_rdy;
                fin_slow     = done_slow | slow_path_send_pkt_enqueue_rdy;
                if (fin_new_flow && fin_app && fin_slow) begin
                    state_next = IDLE;
                end
            end
            DROP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            syn_q         <= 1'b0;
            done_sched    <= 1'b0;
            done_dst      <= 1'b0;
            done_new_flow <= 1'b0;
            done_app      <= 1'b0;
            done_slow     <= 1'b0;
            drop_cnt      <= '0;
        end else begin
            state <= state_next;

            if (ctrl_datap_save_input) begin
                syn_q <= src_tcp_rx_syn;
            end

            // Done bits hold only while the output state remains active.
            // They clear on the exit transition.
            if (state == FP_OUT && state_next == FP_OUT) begin
                done_sched <= fin_sched;
                done_dst   <= fin_dst;
            end else begin
                done_sched <= 1'b0;
                done_dst   <= 1'b0;
            end

            if (state == NF_OUT && state_next == NF_OUT) begin
                done_new_flow <= fin_new_flow;
                done_app      <= fin_app;
                done_slow     <= fin_slow;
            end else begin
                done_new_flow <= 1'b0;
                done_app      <= 1'b0;
                done_slow     <= 1'b0;
            end

            if (state == DROP && drop_cnt != {DROP_CNT_W{1'b1}}) begin
                drop_cnt <= drop_cnt + DROP_CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/tcp_rx_pipe_ctrl.md
# tcp_rx_pipe_ctrl

Control FSM that sequences `tcp_rx_datap` for one received TCP header at a time. It handshakes the parsed header in and runs the flow CAM lookup. On a hit it reads, computes and writes back the per-flow state and then issues the scheduler update and the payload-destination notify. On a SYN miss it allocates a flowid, initialises the flow and enqueues a SYN-ACK. It drives only the datapath's control strobes and the valid/ready signals around the datapath; all data fields come from the datapath.

## Interface
- `DROP_CNT_W`, 16: width of the saturating drop counter.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `src_tcp_rx_hdr_val` in 1 / `tcp_rx_src_hdr_rdy` out 1: header handshake. The header carries the SYN flag on `src_tcp_rx_syn` (in, 1).
- `read_flow_cam_val` out 1 / `read_flow_cam_rdy` in 1: CAM lookup request. The tag comes combinationally from the header inputs.
- `read_flow_cam_resp_val` in 1 / `read_flow_cam_hit` in 1: CAM response.
- `flowid_manager_req` out 1 / `flowid_manager_empty` in 1: flowid pop. A pop returns the flowid in the same cycle.
- `flow_state_rd_req_val` out 1 / `flow_state_rd_req_rdy` in 1 / `flow_state_rd_resp_val` in 1: joint read of RX state, TX state, RX head pointer and RX tail pointer.
- `flow_state_wr_req_val` out 1 / `flow_state_wr_req_rdy` in 1: joint write of next RX state, RX tail pointer and TX head pointer.
- `new_flow_val` out 1 / `new_flow_rdy` in 1: new-flow initial state write.
- `app_new_flow_notif_val` out 1 / `app_new_flow_notif_rdy` in 1: new-flow notify to the application.
- `slow_path_send_pkt_enqueue_val` out 1 / `slow_path_send_pkt_enqueue_rdy` in 1: SYN-ACK enqueue.
- `rx_sched_update_val` out 1 / `rx_sched_update_rdy` in 1: scheduler update.
- `tcp_rx_dst_hdr_val` out 1 / `dst_tcp_rx_hdr_rdy` in 1: notify to the payload destination.
- `ctrl_datap_save_input`, `ctrl_datap_save_flow_state`, `ctrl_datap_save_calcs`, `store_flowid_cam`, `store_flowid_manager`: out, 1 bit each, datapath strobes.
- `drop_cnt` out `DROP_CNT_W`: count of dropped headers.

## Operation
- IDLE: `tcp_rx_src_hdr_rdy = read_flow_cam_rdy`.
  - `read_flow_cam_val = src_tcp_rx_hdr_val`.
  - On a handshake, pulse `ctrl_datap_save_input`, latch the SYN flag and go to LOOKUP.
- LOOKUP: wait for `read_flow_cam_resp_val`.
  - Hit: pulse `store_flowid_cam` and go to RD_REQ.
  - Miss with SYN=1 and `flowid_manager_empty=0`: pulse `flowid_manager_req` and `store_flowid_manager`, then go to NF_OUT.
  - Any other miss: go to DROP.
- RD_REQ: hold `flow_state_rd_req_val` until `rdy`, then go to RD_RESP.
- RD_RESP: on `flow_state_rd_resp_val`, pulse `ctrl_datap_save_flow_state` and go to CALC.
- CALC: pulse `ctrl_datap_save_calcs` for one cycle, then go to WR.
- WR: hold `flow_state_wr_req_val` until `rdy`, then go to FP_OUT.
- FP_OUT: assert `rx_sched_update_val` and `tcp_rx_dst_hdr_val` together.
  - Each valid drops the cycle after its own ready is seen; a done bit per output tracks this.
  - When both are done, clear the done bits and go to IDLE.
- NF_OUT: assert `new_flow_val`, `app_new_flow_notif_val` and `slow_path_send_pkt_enqueue_val` together, with independent done bits as in FP_OUT.
  - When all three are done, go to IDLE.
- DROP: increment `drop_cnt`, saturating at all-ones, for one cycle, then go to IDLE.
- The datapath strobes are mutually exclusive and each lasts exactly one cycle per packet.

## Timing
- Reset values: state IDLE, every valid, ready and strobe output 0, every done bit 0, `drop_cnt` 0.
- Reset acts asynchronously and works mid-operation. An in-flight packet is abandoned with no partial output; downstream blocks see each valid fall during reset.
- Best-case occupancy with every ready held high and 1-cycle CAM/read responses:
  - fast path: 7 cycles from input handshake back to IDLE (LOOKUP, RD_REQ, RD_RESP, CALC, WR, FP_OUT, return);
  - new flow: 3 cycles;
  - drop: 3 cycles.
- The next input is accepted no earlier than the first cycle back in IDLE, so there is no overlap between packets.
- If `read_flow_cam_rdy` is low, `tcp_rx_src_hdr_rdy` stays low and the header is not consumed.
- `flowid_manager_empty` is sampled only in LOOKUP, in the cycle the miss is seen.
- In CALC, the datapath's computed next state must be registered on the `save_calcs` cycle. WR therefore presents registered data.
- A valid never depends combinationally on its own ready.

## Test plan
- CAM hit, every ready high, 1-cycle responses -> strobe sequence `save_input`, `store_flowid_cam`, `rd_req`, `save_flow_state`, `save_calcs`, `wr_req`, then sched+dst valid in the same cycle; back in IDLE 7 cycles after the input handshake.
- CAM miss with SYN=1 and a free flowid -> exactly one `flowid_manager_req`/`store_flowid_manager` pulse; `new_flow`, `app_notif` and `slow_path` valid together; no `flow_state_*` request.
- CAM miss with SYN=0, then a SYN miss with `flowid_manager_empty=1` -> `drop_cnt` goes 0→1→2; no other valid asserts.
- In FP_OUT, `rx_sched_update_rdy` rises at cycle 2 and `dst_tcp_rx_hdr_rdy` at cycle 5 -> sched valid falls after cycle 2, dst valid falls after cycle 5, next input accepted at cycle 6.
- `flow_state_rd_resp_val` delayed 10 cycles -> `save_flow_state` pulses once, exactly in the response cycle; the input stays not-ready throughout.
- Reset asserted in WR with `wr_req_val` high -> all outputs 0 at once; after release, a new header gives a normal hit sequence; `drop_cnt` is 0.
